dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-side bus responder for the multi-cycle CPU: the memory end of the CPU's load/store interface.
- Adds a req/ready handshake with a programmable wait-state count, per-byte write enables, and alignment/range error signalling.
- Holds a word-organised RAM and answers one transaction at a time.
- Sits in the top-level computer between the CPU's data port and the board-level register/debug logic.

Parameters:
- ADDR_W, 7, word-index width; RAM depth 2**ADDR_W words (default 128 words, 512 bytes).
- WAIT_CYCLES, 2, wait states inserted between accept and response (0..15).
- DATA_W, 32, data word width; only 32 is supported.

Ports:
- clk  input  1  CPU clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; sampled with req.
- address  input  32  byte address; bits [ADDR_W+1:2] index the RAM.
- be  input  4  byte enables for stores; be[i] enables byte lane i (bits 8i+7:8i); ignored for loads.
- wdata  input  32  store data; sampled with req.
- rdata  output  32  load data; valid while ready=1; held until the next response.
- ready  output  1  one-cycle response strobe.
- err  output  1  error flag; valid only with ready.
- busy  output  1  high from the cycle after accept through the ready cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; ready=0, err=0, busy=0, rdata=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset takes priority over every other event.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at an edge, accept the transaction: latch we, address, be, wdata.
  - Compute err_pending = (address[1:0]!=0) OR (address[31:ADDR_W+2]!=0).
  - Load the counter with WAIT_CYCLES. Go to WAIT, or straight to RESP if WAIT_CYCLES=0.
- WAIT:
  - Decrement the counter each edge.
  - Enter RESP at the edge where the counter reaches 0.
  - req is ignored.
- RESP:
  - ready=1 for exactly one cycle; err=err_pending.
  - Next edge returns to IDLE unconditionally; req is ignored in this cycle.
- Latency: accept at edge T gives ready=1 during cycle T+1+WAIT_CYCLES.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles; there is always one IDLE cycle between responses.
- Store commit:
  - RAM is written at the same edge that enters RESP, only on lanes with be[i]=1.
  - be=0 is a legal no-op that still responds.
  - An errored store writes nothing.
- Load:
  - rdata is registered at the edge entering RESP as RAM[index], full word.
  - An errored load returns rdata=0.
  - rdata keeps its value after ready drops.
- Stores leave rdata unchanged.
- req held high continuously: re-accepted in each IDLE cycle, giving back-to-back transactions at the throughput above.
- Reset mid-transaction (in WAIT or RESP): aborted, no ready; a pending store that has not yet reached the commit edge is discarded.
- Boundaries:
  - Highest legal address is (2**ADDR_W-1)*4 (0x1FC by default); 0x200 and above flag err.
  - There is no address wrap-around.

Decomposition:
- Shared package (dm_pkg):
  - State encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2.
  - Byte-lane count constant BE_W=4.
  - Default WAIT_CYCLES.
- Sub-module dm_word_ram: synchronous single-port word RAM with per-byte write enables and registered read. The FSM, counter and error check stay in dm_responder.

Test Plan (all with WAIT_CYCLES=2):
- Store 0x00000010 <- 0xDEADBEEF, be=4'hF, accepted at edge 0 -> ready=1, err=0 in cycle 3, busy=1 in cycles 1-3, ready=0 in cycle 4. A following load of 0x10 -> rdata=0xDEADBEEF with ready.
- Byte store to 0x10: be=4'b0010, wdata=0x00005500 -> later load of 0x10 returns 0xDEAD55EF.
- Misaligned store 0x00000012, wdata=0x11111111 -> ready with err=1; a load of 0x10 still returns 0xDEAD55EF. Misaligned load -> err=1, rdata=0.
- Range checks:
  - Store 0x000001FC <- 0xCAFEF00D -> err=0, and a read-back matches.
  - Load 0x00000200 -> err=1, rdata=0.
- req held high for 12 cycles, alternating store/load to 0x20 -> exactly 3 ready pulses 4 cycles apart. A req toggled while busy=1 produces no extra accept.
- Store 0x30 <- 0x12345678 after the same address holds 0xAAAAAAAA; rst=1 in cycle 1 (in WAIT) -> no ready; all outputs 0 next cycle; a later load of 0x30 returns 0xAAAAAAAA.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding and lane constants for the data-side bus responder.
`default_nettype none

package dm_pkg;
  localparam int BE_W                = 4;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/dm_word_ram.sv
// dm_word_ram: single-port word RAM, per-byte write enables, registered read port.
`default_nettype none

module dm_word_ram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// dm_responder: req/ready memory responder with wait states, byte enables and
// alignment/range error reporting.
`default_nettype none

module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       address,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              commit;

  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_idx;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wdata;

  logic              req_err;
  logic              accept;
  logic              use_in;
  logic              c_we;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;
  logic [BE_W-1:0]   c_be;
  logic [DATA_W-1:0] c_wdata;

  assign req_err = (address[1:0] != 2'b00) || (address[31:ADDR_W+2] != '0);
  assign accept  = (state == S_IDLE) && req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      lat_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we    <= we;
        lat_err   <= req_err;
        lat_idx   <= address[ADDR_W+1:2];
        lat_be    <= be;
        lat_wdata <= wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = S_RESP;
            commit   = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = S_RESP;
          commit   = 1'b1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so take the live inputs.
  assign use_in  = (state == S_IDLE);
  assign c_we    = use_in ? we                   : lat_we;
  assign c_err   = use_in ? req_err              : lat_err;
  assign c_idx   = use_in ? address[ADDR_W+1:2]  : lat_idx;
  assign c_be    = use_in ? be                   : lat_be;
  assign c_wdata = use_in ? wdata                : lat_wdata;

  dm_word_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (commit &  c_we & ~c_err),
    .rd_en  (commit & ~c_we & ~c_err),
    .rd_clr (commit & ~c_we &  c_err),
    .addr   (c_idx),
    .be     (c_be),
    .wdata  (c_wdata),
    .rdata  (rdata)
  );

  assign ready = (state == S_RESP);
  assign err   = ready & lat_err;
  assign busy  = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed stimulus with a response scoreboard for dm_responder.
`default_nettype none

module tb_dm_responder;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, err, busy;

  dm_responder #(.ADDR_W(7), .WAIT_CYCLES(WAIT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .address(address), .be(be),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          edge_n;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ecount = 0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) ecount++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready at edge %0d expected none", ecount);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_edge", 32'(ecount), 32'(e.edge_n));
        chk("resp_err", {31'd0, err}, {31'd0, e.err});
        chk("resp_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic push(input logic e, input logic [31:0] rd, input int edge_n);
    exp_t x;
    x.err    = e;
    x.rdata  = rd;
    x.edge_n = edge_n;
    q.push_back(x);
  endtask

  // Loads update the expected held rdata; stores expect it unchanged.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic e, input logic [31:0] rd);
    wait_idle();
    req = 1'b1; we = w; address = a; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0;
    if (!w) last_rd = e ? 32'h0 : rd;
    push(e, last_rd, ecount + WAIT);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // Full-word store with explicit latency/busy window checks.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_c2", {31'd0, busy}, 32'd1);
    chk("ready_c2", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("busy_c3", {31'd0, busy}, 32'd1);
    chk("ready_c3", {31'd0, ready}, 32'd1);
    @(negedge clk);
    chk("ready_c4", {31'd0, ready}, 32'd0);
    chk("busy_c4", {31'd0, busy}, 32'd0);

    issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    issue(1'b1, 32'h10, 4'b0010, 32'h00005500, 1'b0, 32'h0);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEAD55EF);
    issue(1'b1, 32'h12, 4'hF, 32'h11111111, 1'b1, 32'h0);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEAD55EF);
    issue(1'b0, 32'h12, 4'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 32'h1FC, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    issue(1'b0, 32'h1FC, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D);
    issue(1'b0, 32'h200, 4'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 32'h210, 4'hF, 32'h77777777, 1'b1, 32'h0);
    issue(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEAD55EF);
    drain();

    // req held high for 12 cycles: accepts every WAIT+2 edges.
    wait_idle();
    req = 1'b1; we = 1'b1; address = 32'h20; be = 4'hF; wdata = 32'h0BADF00D;
    @(negedge clk);
    e0 = ecount;
    push(1'b0, last_rd, e0 + WAIT);
    push(1'b0, 32'h0BADF00D, e0 + 4 + WAIT);
    push(1'b0, 32'h0BADF00D, e0 + 8 + WAIT);
    last_rd = 32'h0BADF00D;
    we = 1'b0;
    repeat (4) @(negedge clk);
    we = 1'b1; wdata = 32'h600DCAFE;
    repeat (7) @(negedge clk);
    req = 1'b0;
    drain();
    issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h600DCAFE);
    drain();

    // req toggled while busy must not start another transaction.
    issue(1'b1, 32'h40, 4'hF, 32'h00000005, 1'b0, 32'h0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("toggle_busy", {31'd0, busy}, 32'd0);
    drain();
    issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h00000005);
    drain();

    // Reset during WAIT aborts the store before its commit edge.
    issue(1'b1, 32'h30, 4'hF, 32'hAAAAAAAA, 1'b0, 32'h0);
    drain();
    wait_idle();
    req = 1'b1; we = 1'b1; address = 32'h30; be = 4'hF; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_err",   {31'd0, err},   32'd0);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_rdata", rdata, 32'd0);
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'h30, 4'h0, 32'h0, 1'b0, 32'hAAAAAAAA);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
